// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the fetch PC, reads the zero-latency instruction memory and
// queues {instruction, pc} pairs in a small prefetch FIFO for the decode stage.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   word_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;

  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = word_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
  assign halted      = (state == HALTED);

  // A redirect cycle neither consumes nor produces entries; the FIFO is simply flushed.
  assign pop  = instr_valid & instr_ready & ~redirect_valid;
  assign push = (state == RUN) & en & ~redirect_valid & ((count < FULL_COUNT) | pop);

  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = en ? RUN : IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state_next = RUN;
        RUN: begin
          if (!en)
            state_next = IDLE;
          else if (push && (imem_rdata == HALT_WORD))
            state_next = HALTED;
        end
        HALTED:  state_next = HALTED;
        default: state_next = IDLE;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= redirect_pc;
      end else begin
        if (push) begin
          word_mem[wr_ptr] <= imem_rdata;
          pc_mem[wr_ptr]   <= fetch_pc;
          wr_ptr           <= wr_ptr + 1'b1;
          fetch_pc         <= fetch_pc + 32'd1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)
          count <= count + 1'b1;
        else if (pop && !push)
          count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed testbench for fetch_controller with a small combinational instruction memory.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        halted;

  logic [31:0] prog [4];
  int errors = 0;
  int checks = 0;

  fetch_controller dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  // Words 0..3 come from prog; every other address returns a tagged filler word.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a < 32'd4) return prog[a[1:0]];
    return {16'hA5A5, a[15:0]};
  endfunction

  always_comb imem_rdata = word_at(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1; en = 1'b1; instr_ready = ready;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    prog[0] = 32'h4800_0005; prog[1] = 32'h4900_0004;
    prog[2] = 32'h4880_0000; prog[3] = 32'h0000_0013;
    do_reset(1'b1);
    rst = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'd0 ||
        instr !== 32'd0 || instr_pc !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset: valid=%b halted=%b addr=%h instr=%h pc=%h, required 0/0/0/0/0",
               instr_valid, halted, imem_addr, instr, instr_pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h4800_0005; exp_w[1] = 32'h4900_0004; exp_w[2] = 32'h4880_0000;
    do_reset(1'b1);
    tick();
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'd0) begin
      errors++;
      $display("[TB] FAIL stream_start: valid=%b addr=%h, required 0/0", instr_valid, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== exp_w[i] || instr_pc !== 32'(i) ||
          imem_addr !== 32'(i + 1)) begin
        errors++;
        $display("[TB] FAIL stream_%0d: valid=%b instr=%h pc=%h addr=%h, required 1/%h/%h/%h",
                 i, instr_valid, instr, instr_pc, imem_addr, exp_w[i], 32'(i), 32'(i + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    tick(); tick(); tick(); tick();
    checks++;
    if (imem_addr !== 32'd2 || instr_valid !== 1'b1 || instr !== 32'h4800_0005 ||
        instr_pc !== 32'd0) begin
      errors++;
      $display("[TB] FAIL bp_full: addr=%h valid=%b instr=%h pc=%h, required 2/1/48000005/0",
               imem_addr, instr_valid, instr, instr_pc);
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (instr !== 32'h4900_0004 || instr_pc !== 32'd1 || imem_addr !== 32'd3) begin
      errors++;
      $display("[TB] FAIL bp_drain1: instr=%h pc=%h addr=%h, required 49000004/1/3",
               instr, instr_pc, imem_addr);
    end
    tick();
    checks++;
    if (instr !== 32'h4880_0000 || instr_pc !== 32'd2 || instr_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_drain2: instr=%h pc=%h valid=%b, required 48800000/2/1",
               instr, instr_pc, instr_valid);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    tick(); tick();
    instr_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h10; instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h10) begin
      errors++;
      $display("[TB] FAIL redir_flush: valid=%b addr=%h, required 0/10", instr_valid, imem_addr);
    end
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h10 + 32'(i) ||
          instr !== word_at(32'h10 + 32'(i))) begin
        errors++;
        $display("[TB] FAIL redir_target_%0d: valid=%b pc=%h instr=%h, required 1/%h/%h",
                 i, instr_valid, instr_pc, instr, 32'h10 + 32'(i), word_at(32'h10 + 32'(i)));
      end
    end
  endtask

  task automatic test_halt();
    prog[3] = 32'hFFFF_FFFF;
    do_reset(1'b1);
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if (instr !== 32'hFFFF_FFFF || instr_pc !== 32'd3 || halted !== 1'b1 || imem_addr !== 32'd4) begin
      errors++;
      $display("[TB] FAIL halt_capture: instr=%h pc=%h halted=%b addr=%h, required ffffffff/3/1/4",
               instr, instr_pc, halted, imem_addr);
    end
    tick(); tick();
    checks++;
    if (instr_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 32'd4) begin
      errors++;
      $display("[TB] FAIL halt_stopped: valid=%b halted=%b addr=%h, required 0/1/4",
               instr_valid, halted, imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick();
    checks++;
    if (halted !== 1'b0 || imem_addr !== 32'd0 || instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_redirect: halted=%b addr=%h valid=%b, required 0/0/0",
               halted, imem_addr, instr_valid);
    end
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h4800_0005 || instr_pc !== 32'd0) begin
      errors++;
      $display("[TB] FAIL halt_resume: valid=%b instr=%h pc=%h, required 1/48000005/0",
               instr_valid, instr, instr_pc);
    end
    prog[3] = 32'h0000_0013;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    tick(); tick(); tick();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: valid=%b halted=%b addr=%h, required 0/0/0",
               instr_valid, halted, imem_addr);
    end
    rst = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
    tick(); tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr !== 32'h4800_0005) begin
      errors++;
      $display("[TB] FAIL reset_restart: valid=%b pc=%h instr=%h, required 1/0/48000005",
               instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_enable_freeze();
    do_reset(1'b0);
    tick(); tick();
    en = 1'b0;
    tick();
    instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'd1) begin
      errors++;
      $display("[TB] FAIL en_freeze: valid=%b addr=%h, required 0/1", instr_valid, imem_addr);
    end
    en = 1'b1;
    tick(); tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd1 || instr !== 32'h4900_0004) begin
      errors++;
      $display("[TB] FAIL en_resume: valid=%b pc=%h instr=%h, required 1/1/49000004",
               instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFFE; exp_pc[1] = 32'hFFFF_FFFF; exp_pc[2] = 32'd0; exp_pc[3] = 32'd1;
    do_reset(1'b1);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i] || instr !== word_at(exp_pc[i])) begin
        errors++;
        $display("[TB] FAIL wrap_%0d: valid=%b pc=%h instr=%h, required 1/%h/%h",
                 i, instr_valid, instr_pc, instr, exp_pc[i], word_at(exp_pc[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_enable_freeze();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
